// File: rtl/reg_file_param.sv
// Parameterised register bank: two async read ports, one sync write port, reset sweep
// that clears one entry per cycle, optional zero register, bypass and registered outputs.
`timescale 1ns/1ps
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] Din,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic              busy,
  output logic              wr_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] dr1_p0;
  logic [DATA_W-1:0] dr2_p0;

  // An address is usable when it maps to a real entry that is not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = RegWrite && addr_ok(WA);

  // Single write port shared by the clear sweep and normal writes keeps the array RAM-shaped.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = WA[IDX_W-1:0];
    mem_wd = Din;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt[IDX_W-1:0];
        mem_wd = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy   <= 1'b1;
      wr_err <= 1'b0;
    end else begin
      wr_err <= RegWrite && ((state == CLEAR) || !addr_ok(WA));
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          state <= RUN;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Stage p0: combinational read with zero masking and optional write forwarding
  always_comb begin
    dr1_p0 = '0;
    dr2_p0 = '0;
    if (state == RUN) begin
      if (addr_ok(RA1))
        dr1_p0 = ((BYPASS != 0) && wr_ok && (WA == RA1)) ? Din : mem[RA1[IDX_W-1:0]];
      if (addr_ok(RA2))
        dr2_p0 = ((BYPASS != 0) && wr_ok && (WA == RA2)) ? Din : mem[RA2[IDX_W-1:0]];
    end
  end

  // Stage p1: optional output register, one cycle of read latency
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dr1_p1;
      logic [DATA_W-1:0] dr2_p1;
      always_ff @(posedge clk) begin
        if (rst) begin
          dr1_p1 <= '0;
          dr2_p1 <= '0;
        end else begin
          dr1_p1 <= dr1_p0;
          dr2_p1 <= dr2_p0;
        end
      end
      assign DR1 = dr1_p1;
      assign DR2 = dr2_p1;
    end else begin : g_comb
      assign DR1 = dr1_p0;
      assign DR2 = dr2_p0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three configurations (bypass, no bypass,
// registered outputs) share one stimulus stream; a negedge monitor checks queued expectations.
`timescale 1ns/1ps
module tb_reg_file_param;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RegWrite = 1'b0;
  logic [AW-1:0] RA1 = '0;
  logic [AW-1:0] RA2 = '0;
  logic [AW-1:0] WA  = '0;
  logic [DW-1:0] Din = '0;

  logic [DW-1:0] dr1_0, dr2_0, dr1_1, dr2_1, dr1_2, dr2_2;
  logic          busy_0, busy_1, busy_2, wr_err_0, wr_err_1, wr_err_2;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .ZERO_REG(1), .BYPASS(1), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .Din(Din), .RegWrite(RegWrite),
    .DR1(dr1_0), .DR2(dr2_0), .busy(busy_0), .wr_err(wr_err_0));
  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .ZERO_REG(1), .BYPASS(0), .OUT_REG(0)) u1 (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .Din(Din), .RegWrite(RegWrite),
    .DR1(dr1_1), .DR2(dr2_1), .busy(busy_1), .wr_err(wr_err_1));
  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .ZERO_REG(1), .BYPASS(1), .OUT_REG(1)) u2 (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA), .Din(Din), .RegWrite(RegWrite),
    .DR1(dr1_2), .DR2(dr2_2), .busy(busy_2), .wr_err(wr_err_2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic fin_req = 1'b0;

  function automatic logic [31:0] act(input int dut, input int sig);
    logic [31:0] r [3][4];
    r[0][0] = dr1_0; r[0][1] = dr2_0; r[0][2] = {31'b0, busy_0}; r[0][3] = {31'b0, wr_err_0};
    r[1][0] = dr1_1; r[1][1] = dr2_1; r[1][2] = {31'b0, busy_1}; r[1][3] = {31'b0, wr_err_1};
    r[2][0] = dr1_2; r[2][1] = dr2_2; r[2][2] = {31'b0, busy_2}; r[2][3] = {31'b0, wr_err_2};
    return r[dut][sig];
  endfunction

  function automatic string sname(input int s);
    case (s)
      0:       return "DR1";
      1:       return "DR2";
      2:       return "busy";
      default: return "wr_err";
    endcase
  endfunction

  // Monitor: compare every expectation that has come due, then finish on request.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        logic [31:0] a;
        a = act(q[i].dut, q[i].sig);
        checks++;
        if (a !== q[i].exp) begin
          errors++;
          $display("FAIL %s u%0d cyc %0d: got %h, expected %h",
                   sname(q[i].sig), q[i].dut, q[i].cyc, a, q[i].exp);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
    if (fin_req) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic push(input int dly, input int dut, input int sig, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.dut = dut;
    e.sig = sig;
    e.exp = v;
    q.push_back(e);
  endtask

  // b = value on bypass DUTs (u0, and u2 one cycle later), n = value on the no-bypass DUT u1
  task automatic exp_rd(input logic [31:0] d1b, input logic [31:0] d1n,
                        input logic [31:0] d2b, input logic [31:0] d2n);
    push(0, 0, 0, d1b); push(0, 0, 1, d2b);
    push(0, 1, 0, d1n); push(0, 1, 1, d2n);
    push(1, 2, 0, d1b); push(1, 2, 1, d2b);
  endtask

  task automatic exp_ctl(input logic b, input logic e);
    for (int d = 0; d < 3; d++) begin
      push(0, d, 2, {31'b0, b});
      push(1, d, 3, {31'b0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input int wa, input logic [31:0] din, input int ra1, input int ra2);
    RegWrite = rw;
    WA       = 6'(wa);
    Din      = din;
    RA1      = 6'(ra1);
    RA2      = 6'(ra2);
  endtask

  task automatic sweep(input int n, input int err_at);
    for (int k = 0; k < n; k++) begin
      drive(k == err_at, 5, 32'h11, k, k ^ 5);
      exp_rd(0, 0, 0, 0);
      exp_ctl(1'b1, k == err_at);
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DP; a++) begin
      drive(1'b0, 0, 0, a, DP - 1 - a);
      exp_rd(0, 0, 0, 0);
      exp_ctl(1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b1, n1, b2, n2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0, 2, 0, 0); push(0, 2, 1, 0);
    for (int d = 0; d < 3; d++) push(0, d, 3, 0);
    sweep(DP, 3);
    read_all_zero();

    drive(1'b1, 5, 32'hDEADBEEF, 0, 1);
    exp_rd(0, 0, 0, 0); exp_ctl(0, 0); tick();
    drive(1'b0, 0, 0, 5, 5);
    exp_rd(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF); exp_ctl(0, 0); tick();

    drive(1'b1, 7, 32'h12345678, 7, 5);
    exp_rd(32'h12345678, 0, 32'hDEADBEEF, 32'hDEADBEEF); exp_ctl(0, 0); tick();
    drive(1'b0, 0, 0, 7, 7);
    exp_rd(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678); exp_ctl(0, 0); tick();

    drive(1'b1, 0, 32'hFFFFFFFF, 0, 7);
    exp_rd(0, 0, 32'h12345678, 32'h12345678); exp_ctl(0, 1); tick();
    drive(1'b1, 40, 32'hCAFEF00D, 40, 0);
    exp_rd(0, 0, 0, 0); exp_ctl(0, 1); tick();
    drive(1'b0, 0, 0, 8, 63);
    exp_rd(0, 0, 0, 0); exp_ctl(0, 0); tick();
    drive(1'b0, 0, 0, 0, 5);
    exp_rd(0, 0, 32'hDEADBEEF, 32'hDEADBEEF); exp_ctl(0, 0); tick();

    for (int a = 0; a < DP; a++) begin
      drive(1'b1, a, 32'hAAAAAAAA, a, 5);
      b1 = (a == 0) ? 32'h0 : 32'hAAAAAAAA;
      n1 = (a == 5) ? 32'hDEADBEEF : (a == 7) ? 32'h12345678 : 32'h0;
      b2 = (a >= 5) ? 32'hAAAAAAAA : 32'hDEADBEEF;
      n2 = (a > 5)  ? 32'hAAAAAAAA : 32'hDEADBEEF;
      exp_rd(b1, n1, b2, n2); exp_ctl(0, a == 0); tick();
    end
    drive(1'b0, 0, 0, 1, 31);
    exp_rd(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA); exp_ctl(0, 0); tick();

    rst = 1'b1;
    drive(1'b1, 9, 32'h77, 1, 31);
    push(0, 0, 0, 32'hAAAAAAAA); push(0, 0, 1, 32'hAAAAAAAA);
    push(0, 1, 0, 32'hAAAAAAAA); push(0, 1, 1, 32'hAAAAAAAA);
    push(1, 2, 0, 0); push(1, 2, 1, 0);
    exp_ctl(0, 0); tick();
    rst = 1'b0;
    RegWrite = 1'b0;
    sweep(10, -1);
    rst = 1'b1;
    drive(1'b1, 9, 32'h77, 1, 2);
    exp_rd(0, 0, 0, 0); exp_ctl(1, 0); tick();
    rst = 1'b0;
    RegWrite = 1'b0;
    sweep(DP, 2);
    read_all_zero();

    drive(1'b1, 3, 32'h55, 4, 4);
    exp_rd(0, 0, 0, 0); exp_ctl(0, 0); tick();
    drive(1'b0, 0, 0, 3, 3);
    exp_rd(32'h55, 32'h55, 32'h55, 32'h55); exp_ctl(0, 0); tick();
    drive(1'b0, 0, 0, 0, 0);
    exp_rd(0, 0, 0, 0); exp_ctl(0, 0); tick();
    tick();
    tick();
    fin_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL finish_handshake: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised, clocked successor to the datapath register bank (BR): two async-read ports and one synchronous write port.
- Adds optional hardwired zero register, write-to-read bypass and an optional registered-output mode.
- Adds a reset sweep state machine that clears every entry one per cycle, so the array stays RAM-inferable.
- Sits between instruction decode (RA1/RA2/WA) and the ALU/writeback path.

Parameters:
- DATA_W, 32, width of each register and of Din/DR1/DR2
- ADDR_W, 5, address width of RA1/RA2/WA
- DEPTH, 32, number of registers; legal range 2..2**ADDR_W
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
- OUT_REG, 0, 0 = combinational read outputs; 1 = DR1/DR2 registered, 1-cycle latency

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- RA1  in  ADDR_W  read address port 1
- RA2  in  ADDR_W  read address port 2
- WA  in  ADDR_W  write address
- Din  in  DATA_W  write data
- RegWrite  in  1  write enable, sampled at rising clk
- DR1  out  DATA_W  read data port 1
- DR2  out  DATA_W  read data port 2
- busy  out  1  high while reset sweep is in progress
- wr_err  out  1  one-cycle pulse: write dropped (busy, address >= DEPTH, or zero register)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- States: CLEAR, RUN.
- rst=1 at a clk edge: state<=CLEAR, sweep counter<=0, busy<=1, wr_err<=0. If OUT_REG=1, DR1/DR2 registers <=0.
- rst held high keeps the block in CLEAR with counter 0 and no entry written.
- CLEAR: each cycle writes 0 to entry[counter], then counter+1. When counter==DEPTH-1, state<=RUN and busy<=0 on the same edge.
- Sweep length is exactly DEPTH cycles after rst deasserts. busy reads 1 for those DEPTH cycles.
- In CLEAR, DR1/DR2 read 0 regardless of address.
- In CLEAR, RegWrite=1 is dropped and wr_err pulses for 1 cycle.
- rst reasserted mid-sweep restarts the sweep from counter 0.
- Power-up before any rst: contents undefined. The bench must apply rst first.
- RUN write: at rising clk, if RegWrite=1 and WA<DEPTH and not (ZERO_REG and WA==0), then entry[WA]<=Din.
- A write to WA>=DEPTH, or to WA==0 with ZERO_REG=1, is dropped and wr_err pulses high for the next cycle.
- RUN read, OUT_REG=0:
  - DRn = 0 if RAn>=DEPTH, or if ZERO_REG and RAn==0.
  - Otherwise, if BYPASS and RegWrite and WA==RAn and the write is legal, DRn = Din in the same cycle.
  - Otherwise DRn = entry[RAn].
  - Without BYPASS, a read of the address being written returns the old value until after the edge.
- OUT_REG=1: the same combinational value is captured at the rising edge. DRn is valid one cycle after its address is presented.
- Both read ports may use the same address; both return identical data.
- No width truncation: Din is stored full DATA_W. Addresses are compared full ADDR_W.

Test Plan:
- rst 1 cycle, DEPTH=32 -> busy=1 for exactly 32 cycles then 0. Every RA1/RA2 afterwards reads 0x00000000.
- RUN: write WA=5, Din=0xDEADBEEF; next cycle RA1=5, RA2=5 -> DR1=DR2=0xDEADBEEF. wr_err stays 0.
- BYPASS=1: RegWrite=1, WA=7, Din=0x12345678, RA1=7 in the same cycle -> DR1=0x12345678 before the edge. With BYPASS=0, DR1 holds the old value (0) until after the edge.
- ZERO_REG=1: write WA=0, Din=0xFFFFFFFF -> wr_err pulse; RA1=0 reads 0. Write with WA=40 when DEPTH=32, ADDR_W=6 -> wr_err pulse; no entry changes.
- Mid-sweep: assert rst at sweep count 10, fill all entries beforehand with 0xAAAAAAAA -> sweep restarts, busy high 32 more cycles. All entries read 0 afterwards. RegWrite during busy -> wr_err pulse, write dropped.
- OUT_REG=1: write entry 3=0x55, then present RA2=3 -> DR2=0x55 exactly one cycle later. Reset clears DR2 to 0.
